// File: rtl/frodo_decode_seq_if.sv
// Bundle of control, RAM read port and message stream for the FrodoKEM decode sequencer.
// The master modport is the sequencer side; slave is the environment.
interface frodo_decode_seq_if #(
    parameter int ADDR_W = 4
) ();
    logic              start;
    logic [1:0]        level;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [63:0]       mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic              out_last;

    modport master (
        input  start, level, mem_rd_data, out_ready,
        output busy, done, err, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, level, mem_rd_data, out_ready,
        input  busy, done, err, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/frodo_decode_seq.sv
// FrodoKEM message-decode sequencer: reads 16 coefficient words, decodes each
// coefficient to B bits and streams the packed message as 64-bit words.
//   state  | meaning
//   IDLE   | waiting for start
//   READ   | RAM read strobe for word rd_idx
//   WAIT   | RAM data valid, decode and append 4B bits
//   EMIT   | message word offered on the stream
//   DONE   | completion pulse
module frodo_decode_seq #(
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    frodo_decode_seq_if.master  bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]   r_state;
    logic [1:0]   r_level;
    logic [127:0] r_acc;
    logic [6:0]   r_cnt;
    logic [4:0]   r_rd_idx;
    logic [1:0]   r_wcnt;
    logic         r_err;

    logic [15:0]  w_s8 [4];
    logic [15:0]  w_s10 [4];
    logic [15:0]  w_bits;
    logic [6:0]   w_nbits;
    logic [1:0]   w_last_idx;
    logic [6:0]   w_cnt_add;
    logic [6:0]   w_cnt_sub;

    // Rounding offsets: half a decode step for each level, wrapping mod 2^16.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_s8[i]  = bus.mem_rd_data[16*i +: 16] + 16'h0800;
            w_s10[i] = bus.mem_rd_data[16*i +: 16] + 16'h1000;
        end
    end

    always_comb begin
        w_bits     = '0;
        w_nbits    = 7'd0;
        w_last_idx = 2'd0;
        case (r_level)
            2'b01: begin
                for (int i = 0; i < 4; i++) w_bits[4*i +: 4] = w_s8[i][15:12];
                w_nbits    = 7'd16;
                w_last_idx = 2'd3;
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) w_bits[3*i +: 3] = w_s10[i][15:13];
                w_nbits    = 7'd12;
                w_last_idx = 2'd2;
            end
            2'b11: begin
                for (int i = 0; i < 4; i++) w_bits[2*i +: 2] = w_s10[i][14:13];
                w_nbits    = 7'd8;
                w_last_idx = 2'd1;
            end
            default: ;
        endcase
    end

    assign w_cnt_add = r_cnt + w_nbits;
    assign w_cnt_sub = r_cnt - 7'd64;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_level  <= 2'b00;
            r_acc    <= '0;
            r_cnt    <= 7'd0;
            r_rd_idx <= 5'd0;
            r_wcnt   <= 2'd0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.level == 2'b00) begin
                            r_err <= 1'b1;
                        end else begin
                            r_level  <= bus.level;
                            r_acc    <= '0;
                            r_cnt    <= 7'd0;
                            r_rd_idx <= 5'd0;
                            r_wcnt   <= 2'd0;
                            r_state  <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_rd_idx <= r_rd_idx + 5'd1;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // Bits above r_cnt are always zero, so OR-in appends.
                    r_acc <= r_acc | (128'(w_bits) << r_cnt);
                    r_cnt <= w_cnt_add;
                    if (w_cnt_add >= 7'd64)       r_state <= S_EMIT;
                    else if (r_rd_idx < 5'd16)    r_state <= S_READ;
                    else                          r_state <= S_DONE;
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        r_acc  <= r_acc >> 64;
                        r_cnt  <= w_cnt_sub;
                        r_wcnt <= r_wcnt + 2'd1;
                        if (r_rd_idx < 5'd16)         r_state <= S_READ;
                        else if (w_cnt_sub >= 7'd64)  r_state <= S_EMIT;
                        else                          r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.err         = r_err;
    assign bus.mem_rd_en   = (r_state == S_READ);
    assign bus.mem_rd_addr = (r_state == S_READ) ? ADDR_W'(BASE_ADDR) + ADDR_W'(r_rd_idx) : '0;
    assign bus.out_valid   = (r_state == S_EMIT);
    assign bus.out_data    = (r_state == S_EMIT) ? r_acc[63:0] : 64'd0;
    assign bus.out_last    = (r_state == S_EMIT) && (r_wcnt == w_last_idx);
endmodule
